// File: rtl/and_eq_gate.sv
// Per-lane equality gate: sum = c & ~(a ^ b), plus a registered, valid-qualified copy.
// Optional saturating hit counter enabled by defining AND_EQ_GATE_HIT_CNT_EN.
module and_eq_gate #(
    parameter int unsigned W     = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic             in_valid,
    output logic [W-1:0]     sum,
    output logic [W-1:0]     sum_q,
    output logic             out_valid,
    output logic             any_hit,
    output logic [CNT_W-1:0] hit_cnt
);

    logic hit;

    // Lanes are pure bitwise ops, so an X on one lane cannot leak into another.
    assign sum = c & ~(a ^ b);
    assign hit = |sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            out_valid <= 1'b0;
            any_hit   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                any_hit <= hit;
            end
        end
    end

`ifdef AND_EQ_GATE_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;

    // Saturates at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else if (in_valid && hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_and_eq_gate.sv
// Directed self-checking bench for and_eq_gate: W=1 (CNT_W=2) and W=4 instances.
module tb_and_eq_gate;

`ifdef AND_EQ_GATE_HIT_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, v1 = 1'b0;
    logic       sum1, sum_q1, out_valid1, any_hit1;
    logic [1:0] hit_cnt1;

    logic [3:0]  a4 = '0, b4 = '0, c4 = '0;
    logic        v4 = 1'b0;
    logic [3:0]  sum4, sum_q4;
    logic        out_valid4, any_hit4;
    logic [15:0] hit_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    and_eq_gate #(.W(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(v1),
        .sum(sum1), .sum_q(sum_q1), .out_valid(out_valid1), .any_hit(any_hit1),
        .hit_cnt(hit_cnt1)
    );

    and_eq_gate #(.W(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .in_valid(v4),
        .sum(sum4), .sum_q(sum_q4), .out_valid(out_valid4), .any_hit(any_hit4),
        .hit_cnt(hit_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected counter value; zero when the counter is compiled out.
    function automatic logic [31:0] cnt(input int n);
        return CntEn ? 32'(n) : 32'd0;
    endfunction

    task automatic check_reg1(input string tag, input logic q, input logic ov, input logic ah,
                              input int n);
        check({tag, ".sum_q"}, 32'(sum_q1), 32'(q));
        check({tag, ".out_valid"}, 32'(out_valid1), 32'(ov));
        check({tag, ".any_hit"}, 32'(any_hit1), 32'(ah));
        check({tag, ".hit_cnt"}, 32'(hit_cnt1), cnt(n));
    endtask

    initial begin
        logic [7:0] tt;
        tt = 8'b1000_0010;  // bit {a,b,c}: only 001 and 111 give 1

        // Combinational sweep under reset, in_valid low.
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #10;
            check($sformatf("sweep_%03b", 3'(i)), 32'(sum1), 32'(tt[i]));
        end

        // Reset with active inputs: registered outputs stay cleared, sum follows inputs.
        {a1, b1, c1} = 3'b111;
        v1 = 1'b1;
        tick();
        tick();
        check_reg1("reset", 1'b0, 1'b0, 1'b0, 0);
        check("reset.sum", 32'(sum1), 32'd1);
        check("reset.out_valid4", 32'(out_valid4), 32'd0);

        // Latency: one accepted hit, then idle with a changed.
        rst = 1'b0;
        tick();
        check_reg1("lat_accept", 1'b1, 1'b1, 1'b1, 1);
        v1 = 1'b0;
        a1 = 1'b0;
        tick();
        check_reg1("lat_hold", 1'b1, 1'b0, 1'b1, 1);
        check("lat_hold.sum", 32'(sum1), 32'd0);

        // Four more accepted hits: counter saturates at 3.
        a1 = 1'b1;
        v1 = 1'b1;
        tick(); check_reg1("cnt2", 1'b1, 1'b1, 1'b1, 2);
        tick(); check_reg1("cnt3", 1'b1, 1'b1, 1'b1, 3);
        tick(); check_reg1("cnt_sat4", 1'b1, 1'b1, 1'b1, 3);
        tick(); check_reg1("cnt_sat5", 1'b1, 1'b1, 1'b1, 3);

        // Accepted miss clears sum_q/any_hit without touching the counter.
        b1 = 1'b0;
        tick();
        check_reg1("miss", 1'b0, 1'b1, 1'b0, 3);

        // Clean reset, two hits, then mid-stream reset with valid held high.
        rst = 1'b1;
        b1 = 1'b1;
        tick();
        rst = 1'b0;
        tick(); check_reg1("mid_hit1", 1'b1, 1'b1, 1'b1, 1);
        tick(); check_reg1("mid_hit2", 1'b1, 1'b1, 1'b1, 2);
        rst = 1'b1;
        tick();
        check_reg1("mid_rst", 1'b0, 1'b0, 1'b0, 0);
        check("mid_rst.sum", 32'(sum1), 32'd1);
        rst = 1'b0;
        tick();
        check_reg1("post_rst", 1'b1, 1'b1, 1'b1, 1);
        v1 = 1'b0;

        // W=4 lane independence.
        a4 = 4'b1010;
        b4 = 4'b1001;
        c4 = 4'b1111;
        #1;
        check("w4_sum_all_en", 32'(sum4), 32'hC);
        v4 = 1'b1;
        tick();
        check("w4_sum_q", 32'(sum_q4), 32'hC);
        check("w4_any_hit", 32'(any_hit4), 32'd1);
        check("w4_out_valid", 32'(out_valid4), 32'd1);
        check("w4_hit_cnt", 32'(hit_cnt4), cnt(1));
        c4 = 4'b0100;
        #1;
        check("w4_sum_c0100", 32'(sum4), 32'h4);
        c4 = 4'b0011;
        tick();
        check("w4_sum_c0011", 32'(sum4), 32'h0);
        check("w4_miss_any_hit", 32'(any_hit4), 32'd0);
        check("w4_miss_sum_q", 32'(sum_q4), 32'h0);
        check("w4_miss_hit_cnt", 32'(hit_cnt4), cnt(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_eq_gate.md
Name: and_eq_gate

Overview:
- Three-input gating cell: output bit is 1 only when enable input c is 1 and inputs a and b are equal, i.e. sum = c & ~(a ^ b), per lane.
- Provides a combinational result for glue logic and a registered, valid-qualified copy with hit statistics for pipelined consumers.
- Sits in datapath compare/enable stages; W lanes evaluated independently.

Parameters:
- W, 1, number of independent lanes (bit width of a, b, c, sum, sum_q).
- CNT_W, 16, width of the hit counter.

Ports:
- clk  input  1  single clock; all registers update on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  W  operand A per lane.
- b  input  W  operand B per lane.
- c  input  W  per-lane enable.
- in_valid  input  1  qualifies a/b/c for the registered path only.
- sum  output  W  combinational result, c & ~(a ^ b), bitwise.
- sum_q  output  W  registered sum, captured when in_valid=1.
- out_valid  output  1  in_valid delayed by one cycle.
- any_hit  output  1  registered OR-reduction of sum, captured when in_valid=1.
- hit_cnt  output  CNT_W  count of accepted cycles with any_hit (see Optional Feature).

Behaviour:
- sum is purely combinational, independent of clk, rst and in_valid; settles within the same delta cycle as its inputs change. No latches.
- Truth table per lane (a b c -> sum): 000->0, 001->1, 010->0, 011->0, 100->0, 101->0, 110->0, 111->1.
- X/Z on any input bit of a lane may produce X on that lane only; other lanes are unaffected.
- Registered path, on each rising clk:
  - rst=1: sum_q=0, out_valid=0, any_hit=0, hit_cnt=0. Reset has priority over all other activity.
  - rst=0, in_valid=1: sum_q<=sum, any_hit<=|sum, out_valid<=1.
  - rst=0, in_valid=0: sum_q and any_hit hold their values; out_valid<=0.
- Latency: registered outputs reflect inputs sampled 1 cycle earlier. sum has zero latency.
- Reset asserted mid-stream clears the registered outputs on the next edge. The combinational sum keeps following the inputs during reset.
- After reset deassertion, the first accepted input appears on sum_q on the following edge.

Optional Feature:
- Macro: AND_EQ_GATE_HIT_CNT_EN.
- Defined: hit_cnt increments by 1 on each edge where rst=0, in_valid=1 and |sum=1. It saturates at all-ones and does not wrap. It clears to 0 on reset.
- Not defined: hit_cnt is tied to constant 0 and no counter flops are inferred. All other behaviour is unchanged.

Test Plan:
- Exhaustive W=1 combinational sweep: apply all 8 (a,b,c) combos, wait 10 time units each -> sum matches the truth table above; in particular 001->1 and 111->1, all others 0.
- Reset: drive rst=1 for 2 cycles with a=b=c=1 and in_valid=1 -> sum_q=0, out_valid=0, any_hit=0, hit_cnt=0, while sum=1.
- Registered latency: rst=0, in_valid=1, a=1, b=1, c=1 on cycle N; then in_valid=0 with a=0 from cycle N+1 -> sum_q=1, any_hit=1, out_valid=1 after edge N+1; sum_q holds 1 and out_valid=0 after edge N+2.
- W=4 lane independence: a=4'b1010, b=4'b1001, c=4'b1111 -> sum=4'b1100; with c=4'b0100 -> sum=4'b0100.
- Counter (macro defined, CNT_W=2): 5 accepted cycles with a=b=c=1 -> hit_cnt reads 1,2,3,3,3. Without the macro, hit_cnt stays 0.
- Mid-stream reset: after 2 hits, assert rst for 1 cycle -> all registered outputs return to 0; the next accepted hit gives hit_cnt=1.
